// File: rtl/fll_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fll_ctrl
// Purpose  : Frequency-lock controller. Sequences the pfd (reset, settle,
//            measure) and binary-searches the DCO code until neither the
//            fast nor the slow indication appears over a full window.
// Ports    : ref_clk   - the only clock
//            rst       - asynchronous active-high reset
//            start     - pulse, begins acquisition from IDLE
//            stop      - level, forces IDLE (highest priority)
//            fast/slow - pfd indications, asynchronous to ref_clk
//            pfd_rst_n - active-low reset to the pfd
//            dco_code  - registered DCO control word
//            busy      - high in every state except IDLE
//            locked    - high while lock is held
//            sat       - clip indication (FLL_CTRL_SAT_EN builds only)
// Config   : `define FLL_CTRL_SAT_EN adds the sat port and stops acquisition
//            after 3 consecutive clipped adjusts in the same direction.
// Revision : 1.0 - initial release
// ============================================================================
module fll_ctrl #(
  parameter int CODE_W    = 8,
  parameter int CODE_INIT = 128,
  parameter int STEP_INIT = 32,
  parameter int SETTLE    = 8,
  parameter int WIN       = 64,
  parameter int LOCK_CNT  = 4
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              fast,
  input  logic              slow,
  output logic              pfd_rst_n,
  output logic [CODE_W-1:0] dco_code,
  output logic              busy,
  output logic              locked
`ifdef FLL_CTRL_SAT_EN
  ,
  output logic              sat
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_ADJUST  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  localparam int CNT_MAX = (WIN > SETTLE) ? WIN : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int INB_W   = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  c_cnt_one    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_clear_last = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_settle_last = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  c_win_last   = CNT_W'(WIN - 1);
  localparam logic [INB_W-1:0]  c_inb_one    = INB_W'(1);
  localparam logic [INB_W-1:0]  c_lock_last  = INB_W'(LOCK_CNT - 1);
  localparam logic [INB_W-1:0]  c_lock_cnt   = INB_W'(LOCK_CNT);
  localparam logic [CODE_W-1:0] c_code_init  = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-1:0] c_step_init  = CODE_W'(STEP_INIT);
  localparam logic [CODE_W-1:0] c_step_one   = CODE_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  step_q, step_d;
  dir_t               dir_q, dir_d;
  logic [INB_W-1:0]   inb_q, inb_d;
  logic               locked_q, locked_d;
  logic               f_seen_q, f_seen_d;
  logic               s_seen_q, s_seen_d;
  logic [1:0]         fast_sync_q, slow_sync_q;

  dir_t               w_dir_new;
  logic [CODE_W-1:0]  w_step_eff;
  logic [CODE_W:0]    w_sum, w_diff;
  logic [CODE_W-1:0]  w_code_adj;

`ifdef FLL_CTRL_SAT_EN
  logic               sat_q, sat_d;
  logic [1:0]         clip_cnt_q, clip_cnt_d;
  dir_t               clip_dir_q, clip_dir_d;
  logic               w_clip;
`endif

  // 2-flop synchronizers; flushed in CLEAR so a stale event from the
  // previous iteration cannot leak into the next window.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      fast_sync_q <= 2'b00;
      slow_sync_q <= 2'b00;
    end else if (state_q == ST_CLEAR) begin
      fast_sync_q <= 2'b00;
      slow_sync_q <= 2'b00;
    end else begin
      fast_sync_q <= {fast_sync_q[0], fast};
      slow_sync_q <= {slow_sync_q[0], slow};
    end
  end

  // Adjust arithmetic, evaluated from the sticky flags of the last window.
  always_comb begin
    w_dir_new = DIR_NONE;
    if (f_seen_q && !s_seen_q) begin
      w_dir_new = DIR_UP;
    end else if (s_seen_q && !f_seen_q) begin
      w_dir_new = DIR_DN;
    end

    // Losing lock always falls back to the finest step; otherwise a
    // reversal halves the step before it is applied.
    w_step_eff = step_q;
    if (locked_q) begin
      w_step_eff = c_step_one;
    end else if (dir_q != DIR_NONE && w_dir_new != DIR_NONE && dir_q != w_dir_new) begin
      w_step_eff = (step_q > c_step_one) ? (step_q >> 1) : c_step_one;
    end

    // One extra bit catches carry-out / borrow so results clip, never wrap.
    w_sum  = {1'b0, code_q} + {1'b0, w_step_eff};
    w_diff = {1'b0, code_q} - {1'b0, w_step_eff};
    if (w_dir_new == DIR_UP) begin
      w_code_adj = w_sum[CODE_W] ? '1 : w_sum[CODE_W-1:0];
    end else begin
      w_code_adj = w_diff[CODE_W] ? '0 : w_diff[CODE_W-1:0];
    end
`ifdef FLL_CTRL_SAT_EN
    w_clip = (w_dir_new == DIR_UP) ? w_sum[CODE_W] : w_diff[CODE_W];
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    step_d   = step_q;
    dir_d    = dir_q;
    inb_d    = inb_q;
    locked_d = locked_q;
    f_seen_d = f_seen_q;
    s_seen_d = s_seen_q;
`ifdef FLL_CTRL_SAT_EN
    sat_d      = sat_q;
    clip_cnt_d = clip_cnt_q;
    clip_dir_d = clip_dir_q;
`endif

    if (stop) begin
      // dco_code deliberately holds its value here.
      state_d  = ST_IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_CLEAR;
            cnt_d    = '0;
            code_d   = c_code_init;
            step_d   = c_step_init;
            dir_d    = DIR_NONE;
            inb_d    = '0;
            locked_d = 1'b0;
`ifdef FLL_CTRL_SAT_EN
            sat_d      = 1'b0;
            clip_cnt_d = 2'd0;
            clip_dir_d = DIR_NONE;
`endif
          end
        end
        ST_CLEAR: begin
          f_seen_d = 1'b0;
          s_seen_d = 1'b0;
          if (cnt_q == c_clear_last) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == c_settle_last) begin
            state_d = ST_MEASURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        ST_MEASURE: begin
          f_seen_d = f_seen_q | fast_sync_q[1];
          s_seen_d = s_seen_q | slow_sync_q[1];
          if (cnt_q == c_win_last) begin
            state_d = ST_ADJUST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        ST_ADJUST: begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          if (w_dir_new != DIR_NONE) begin
            code_d   = w_code_adj;
            step_d   = w_step_eff;
            dir_d    = w_dir_new;
            inb_d    = '0;
            locked_d = 1'b0;
`ifdef FLL_CTRL_SAT_EN
            if (w_clip) begin
              sat_d      = 1'b1;
              clip_cnt_d = (clip_cnt_q != 2'd0 && clip_dir_q == w_dir_new) ?
                           clip_cnt_q + 2'd1 : 2'd1;
              clip_dir_d = w_dir_new;
              if (clip_cnt_d == 2'd3) begin
                state_d = ST_IDLE;
              end
            end else begin
              sat_d      = 1'b0;
              clip_cnt_d = 2'd0;
            end
`endif
          end else if (!f_seen_q && !s_seen_q) begin
            // In-band window; the count saturates once lock is reached.
            if (inb_q < c_lock_cnt) begin
              inb_d = inb_q + c_inb_one;
            end
            if (inb_q >= c_lock_last) begin
              locked_d = 1'b1;
            end
          end else begin
            // Both flags: glitch window, code untouched.
            inb_d = '0;
            if (locked_q) begin
              locked_d = 1'b0;
              step_d   = c_step_one;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      code_q   <= c_code_init;
      step_q   <= c_step_init;
      dir_q    <= DIR_NONE;
      inb_q    <= '0;
      locked_q <= 1'b0;
      f_seen_q <= 1'b0;
      s_seen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      inb_q    <= inb_d;
      locked_q <= locked_d;
      f_seen_q <= f_seen_d;
      s_seen_q <= s_seen_d;
    end
  end

`ifdef FLL_CTRL_SAT_EN
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      sat_q      <= 1'b0;
      clip_cnt_q <= 2'd0;
      clip_dir_q <= DIR_NONE;
    end else begin
      sat_q      <= sat_d;
      clip_cnt_q <= clip_cnt_d;
      clip_dir_q <= clip_dir_d;
    end
  end

  assign sat = sat_q;
`endif

  assign dco_code  = code_q;
  assign busy      = (state_q != ST_IDLE);
  assign locked    = locked_q;
  assign pfd_rst_n = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) ||
                     (state_q == ST_ADJUST);

endmodule
`default_nettype wire

// File: tb/tb_fll_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fll_ctrl
// Purpose  : Self-checking bench for fll_ctrl (default build). A behavioural
//            DCO/pfd model drives fast/slow from the DUT code and a target
//            code; a reference model predicts code/lock after every window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fll_ctrl;

  localparam int ITER = 75;  // 2 + SETTLE + WIN + 1

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic       fast, slow;
  logic       pfd_rst_n, busy, locked;
  logic [7:0] dco_code;

  int  target   = 128;
  bit  use_model = 1'b0;
  bit  hold_f = 1'b0, hold_s = 1'b0;
  bit  pul_f  = 1'b0, pul_s  = 1'b0;

  int  checks = 0;
  int  errors = 0;

  // Reference model state
  int  m_code, m_step, m_dir, m_cnt;
  bit  m_locked;

  always #5 clk = ~clk;

  // Idealised pfd + DCO: feedback slower than reference while code < target.
  assign fast = pfd_rst_n & (hold_f | pul_f | (use_model & (int'(dco_code) < target)));
  assign slow = pfd_rst_n & (hold_s | pul_s | (use_model & (int'(dco_code) > target)));

  fll_ctrl dut (
    .ref_clk   (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .fast      (fast),
    .slow      (slow),
    .pfd_rst_n (pfd_rst_n),
    .dco_code  (dco_code),
    .busy      (busy),
    .locked    (locked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start();
    m_code   = 128;
    m_step   = 32;
    m_dir    = 0;
    m_cnt    = 0;
    m_locked = 1'b0;
  endtask

  // Binary-search rules applied to one window's observed flags.
  task automatic model_adjust(input bit f, input bit s);
    int d;
    if (f != s) begin
      d = f ? 1 : -1;
      if (m_locked) m_step = 1;
      else if (m_dir != 0 && m_dir != d) m_step = (m_step > 1) ? m_step / 2 : 1;
      m_code = m_code + d * m_step;
      if (m_code > 255) m_code = 255;
      if (m_code < 0)   m_code = 0;
      m_dir    = d;
      m_cnt    = 0;
      m_locked = 1'b0;
    end else if (!f) begin
      m_cnt++;
      if (m_cnt >= 4) m_locked = 1'b1;
    end else begin
      if (m_locked) m_step = 1;
      m_cnt    = 0;
      m_locked = 1'b0;
    end
  endtask

  task automatic go_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: busy=%0b required 1", busy);
    end
  endtask

  // One full iteration starting just after the edge that began it.
  // gf/gs: cycle at which a one-cycle fast/slow pulse is injected (0 = none).
  // st_at: cycle at which a stray start pulse is driven (0 = none).
  task automatic run_iter(input int gf, input int gs, input int st_at);
    bit f, s;
    int prev;
    prev = m_code;
    f = hold_f || (gf > 0) || (use_model && m_code < target);
    s = hold_s || (gs > 0) || (use_model && m_code > target);
    for (int c = 1; c <= ITER; c++) begin
      pul_f = (c == gf);
      pul_s = (c == gs);
      start = (c == st_at);
      tick();
      pul_f = 1'b0;
      pul_s = 1'b0;
      start = 1'b0;
      if (c == 1) begin
        checks++;
        if (pfd_rst_n !== 1'b0) begin
          errors++;
          $display("FAIL pfd_clear: pfd_rst_n=%0b required 0", pfd_rst_n);
        end
      end
      if (c == 2) begin
        checks++;
        if (pfd_rst_n !== 1'b1) begin
          errors++;
          $display("FAIL pfd_settle: pfd_rst_n=%0b required 1", pfd_rst_n);
        end
      end
      if (c == ITER - 1) begin
        checks++;
        if (dco_code !== 8'(prev)) begin
          errors++;
          $display("FAIL code_hold: dco_code=%0d required %0d", dco_code, prev);
        end
      end
    end
    model_adjust(f, s);
    checks++;
    if (dco_code !== 8'(m_code) || locked !== m_locked || busy !== 1'b1) begin
      errors++;
      $display("FAIL iter_result: code=%0d locked=%0b busy=%0b required code=%0d locked=%0b busy=1",
               dco_code, locked, busy, m_code, m_locked);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    tick();
    checks++;
    if (dco_code !== 8'd128 || pfd_rst_n !== 1'b0 || busy !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: code=%0d pfd_rst_n=%0b busy=%0b locked=%0b required 128/0/0/0",
               dco_code, pfd_rst_n, busy, locked);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_converge(input int t, input bit check_seq);
    int n;
    logic [7:0] last;
    logic [7:0] seen[$];
    int exp_seq[5] = '{160, 144, 152, 148, 150};
    go_idle();
    use_model = 1'b1;
    target    = t;
    do_start();
    last = dco_code;
    n = 0;
    while (!m_locked && n < 40) begin
      run_iter(0, 0, 0);
      if (dco_code !== last) seen.push_back(dco_code);
      last = dco_code;
      n++;
    end
    checks++;
    if (!m_locked || locked !== 1'b1 || dco_code !== 8'(t)) begin
      errors++;
      $display("FAIL converge_lock: target=%0d code=%0d locked=%0b required code=%0d locked=1",
               t, dco_code, locked, t);
    end
    // One more clean window must keep lock.
    run_iter(0, 0, 0);
    if (check_seq) begin
      checks++;
      if (seen.size() != 5) begin
        errors++;
        $display("FAIL code_sequence_len: got %0d codes required 5", seen.size());
      end else begin
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (seen[i] !== 8'(exp_seq[i])) begin
            errors++;
            $display("FAIL code_sequence[%0d]: code=%0d required %0d", i, seen[i], exp_seq[i]);
          end
        end
      end
    end
  endtask

  // Entered while locked at 150: the DCO drifts so the code now reads slow.
  task automatic test_lock_loss();
    target = 149;
    run_iter(0, 0, 0);
    checks++;
    if (locked !== 1'b0 || dco_code !== 8'd149) begin
      errors++;
      $display("FAIL lock_loss: locked=%0b code=%0d required locked=0 code=149", locked, dco_code);
    end
    for (int i = 0; i < 4; i++) run_iter(0, 0, 0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock: locked=%0b required 1 after 4 clean windows", locked);
    end
  endtask

  // Entered locked, at the start of an iteration.
  task automatic test_async_reset();
    for (int i = 0; i < 40; i++) tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (dco_code !== 8'd128 || pfd_rst_n !== 1'b0 || busy !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: code=%0d pfd_rst_n=%0b busy=%0b locked=%0b required 128/0/0/0",
               dco_code, pfd_rst_n, busy, locked);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    int gf, gs, n;
    go_idle();
    use_model = 1'b1;
    target    = 128;
    do_start();
    run_iter(0, 0, 0);
    run_iter(0, 0, 0);
    gf = $urandom_range(12, 70);
    gs = $urandom_range(12, 70);
    run_iter(gf, gs, 0);
    checks++;
    if (dco_code !== 8'd128 || locked !== 1'b0) begin
      errors++;
      $display("FAIL glitch_window: code=%0d locked=%0b required code=128 locked=0", dco_code, locked);
    end
    n = 0;
    while (!m_locked && n < 10) begin
      run_iter(0, 0, 0);
      n++;
    end
    checks++;
    if (n != 4 || locked !== 1'b1) begin
      errors++;
      $display("FAIL glitch_relock: windows=%0d locked=%0b required 4 windows locked=1", n, locked);
    end
  endtask

  task automatic test_precedence();
    go_idle();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_same: busy=%0b required 0", busy);
    end
    // Stray start mid-MEASURE must not disturb the iteration.
    use_model = 1'b1;
    target    = $urandom_range(140, 255);
    do_start();
    run_iter(0, 0, $urandom_range(12, 70));
    // Stop while in SETTLE.
    for (int i = 0; i < 5; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || pfd_rst_n !== 1'b0 || locked !== 1'b0 || dco_code !== 8'(m_code)) begin
      errors++;
      $display("FAIL stop_settle: busy=%0b pfd_rst_n=%0b locked=%0b code=%0d required 0/0/0 code=%0d",
               busy, pfd_rst_n, locked, dco_code, m_code);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (busy !== 1'b0 || dco_code !== 8'(m_code)) begin
      errors++;
      $display("FAIL stop_hold: busy=%0b code=%0d required busy=0 code=%0d", busy, dco_code, m_code);
    end
  endtask

  task automatic test_saturation();
    go_idle();
    use_model = 1'b0;
    hold_f    = 1'b1;
    do_start();
    for (int i = 0; i < 6; i++) run_iter(0, 0, 0);
    checks++;
    if (dco_code !== 8'd255 || busy !== 1'b1) begin
      errors++;
      $display("FAIL saturation: code=%0d busy=%0b required code=255 busy=1", dco_code, busy);
    end
    hold_f = 1'b0;
    go_idle();
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 3; i++) test_converge($urandom_range(0, 255), 1'b0);
    test_converge(150, 1'b1);
    test_lock_loss();
    test_async_reset();
    test_glitch();
    test_precedence();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fll_ctrl.md
# fll_ctrl

Frequency-lock controller that sequences the phase/frequency detector (`pfd`) and steers a DCO control word until the feedback clock matches `ref_clk`. It resets the detector, waits for settling, samples the `fast`/`slow` indications over a fixed measurement window, and adjusts the code by a binary-search step that halves on every direction reversal. It sits between the `pfd` instance and the DCO code input, in the `ref_clk` domain.

## Interface

Parameters:
- `CODE_W`, 8: DCO code width.
- `CODE_INIT`, 128: code loaded on reset and on `start`.
- `STEP_INIT`, 32: first adjustment step; power of two, ≤ 2^(CODE_W-1).
- `SETTLE`, 8: `ref_clk` cycles waited after releasing the detector reset; ≥ 1.
- `WIN`, 64: measurement window length in `ref_clk` cycles; ≥ 4.
- `LOCK_CNT`, 4: consecutive in-band windows needed to declare lock; ≥ 1.

Ports:
- `ref_clk`  in  1: the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins acquisition from IDLE.
- `stop`  in  1: level; forces return to IDLE.
- `fast`  in  1: from `pfd`; asynchronous to `ref_clk`.
- `slow`  in  1: from `pfd`; asynchronous to `ref_clk`.
- `pfd_rst_n`  out  1: active-low reset driven to `pfd`.
- `dco_code`  out  CODE_W: registered DCO control word.
- `busy`  out  1: high in every state except IDLE.
- `locked`  out  1: high only in LOCKED.
- `sat`  out  1: only with `FLL_CTRL_SAT_EN`; see Configuration.

## Operation

- `fast`/`slow` pass through 2-flop synchronizers. Only the synchronized copies are used.
- The `pfd` asserts `slow` when its feedback count leads the reference by more than one edge, which drives a code decrement. It asserts `fast` when the feedback count lags by more than one edge, which drives a code increment.
- **IDLE:**
  - `pfd_rst_n`=0, `busy`=0.
  - `start` loads `dco_code`=CODE_INIT, step=STEP_INIT, direction=none, in-band count=0, then goes to CLEAR.
- **CLEAR:**
  - Holds `pfd_rst_n`=0 for 2 cycles, then goes to SETTLE.
  - Clears the synchronizer and sticky flags.
- **SETTLE:**
  - `pfd_rst_n`=1.
  - Counts SETTLE cycles, then goes to MEASURE.
- **MEASURE:**
  - Runs for WIN cycles.
  - Sticky flags `f_seen`/`s_seen` OR-accumulate the synchronized `fast`/`slow`.
  - Goes to ADJUST after the last cycle.
- **ADJUST (1 cycle):**
  - Only `f_seen`: new direction is up, code += step.
  - Only `s_seen`: new direction is down, code −= step.
  - On a reversal against the previous non-none direction, the step is halved first (floor 1), then applied.
  - A non-none result clears the in-band count and goes to CLEAR.
  - Neither flag: in-band count +1. If the count reaches LOCK_CNT, go to LOCKED; otherwise go to CLEAR.
  - Both flags: treated as a glitch window. No code change, in-band count cleared, go to CLEAR.
- **LOCKED:**
  - `locked`=1.
  - Keeps running the CLEAR→SETTLE→MEASURE cycle with `locked` held. A neither-flag window keeps lock.
  - Any other window result drops `locked`, forces step=1, applies the adjust as above, and returns to tracking.
- **Arithmetic:**
  - Code math is done at CODE_W+1 bits.
  - Results saturate to 0 and 2^CODE_W−1. There is never wrap-around.
- **Input precedence:**
  - `stop` has priority over everything. From any state it goes to IDLE next cycle; `dco_code` keeps its value and `locked` is cleared.
  - `start` while `busy` is ignored.
  - `start` and `stop` in the same cycle: `stop` wins.

## Timing

- **Reset values:**
  - `dco_code`=CODE_INIT.
  - `pfd_rst_n`=0.
  - `busy`=0, `locked`=0, `sat`=0.
  - State is IDLE.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous).
- **Latencies:**
  - `start` to `busy`=1: 1 cycle.
  - Iteration length: 2 + SETTLE + WIN + 1 cycles (75 cycles at default parameters).
  - `dco_code` updates on the clock edge that ends ADJUST.
  - `locked` rises in the same cycle the state becomes LOCKED.
- **Synchronizer latency:** 2 cycles. A detector event in the last 2 cycles of a window is missed for that window, which is acceptable because the window restarts.

## Configuration

- **`FLL_CTRL_SAT_EN` defined:**
  - Adds output `sat`.
  - `sat` is set when an adjust is clipped at either limit and cleared on a non-clipped adjust or on `start`.
  - After 3 consecutive clipped adjusts in the same direction, the controller goes to IDLE with `sat`=1.
- **`FLL_CTRL_SAT_EN` not defined:**
  - No `sat` port.
  - Clipping saturates silently and acquisition continues indefinitely.

## Test plan

- **Reset:** assert `rst` mid-MEASURE → `dco_code`=128, `pfd_rst_n`=0, `busy`=0, `locked`=0 on the same cycle.
- **Upward convergence:** model DCO target code 150, `start` → codes 160, 144, 152, 148, 150. `locked`=1 after 4 in-band windows. `fast`/`slow` never seen while at 150.
- **Lock loss:** in LOCKED, force `slow` for one window → `locked` falls, `dco_code` decrements by exactly 1, re-lock occurs after 4 clean windows.
- **Saturation (with `FLL_CTRL_SAT_EN`):** hold `fast`=1 with CODE_INIT=250 → code goes to 255 and stays, `sat`=1, IDLE after 3 clipped adjusts. Without the macro: code stays at 255 and `busy` stays 1.
- **Control precedence:** pulse `start` and `stop` in the same cycle in IDLE → stays IDLE. `start` during MEASURE → ignored, iteration timing unchanged. `stop` during SETTLE → IDLE next cycle, `dco_code` held.
- **Glitch window:** `fast` and `slow` both pulsed within one window → no code change, in-band count reset.
